// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, drives the imem request/ack port and hands
// instructions to decode through an output register backed by a one-entry skid register.
module fetch_stage #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [4:0]        NOP_OP   = 5'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              dec_valid,
   input  logic              dec_ready,
   output logic [31:0]       dec_instr,
   output logic [ADDR_W-1:0] dec_pc,
   output logic [4:0]        next_opCode,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} fetchState_t;

   fetchState_t       state, stateNext;
   logic [ADDR_W-1:0] pc, pcNext;
   logic [ADDR_W-1:0] drainAddr, drainAddrNext;
   logic              outValid, outValidNext;
   logic [31:0]       outInstr, outInstrNext;
   logic [ADDR_W-1:0] outPc, outPcNext;
   logic [4:0]        nextOp, nextOpNext;
   logic              skidValid, skidValidNext;
   logic [31:0]       skidInstr, skidInstrNext;
   logic [ADDR_W-1:0] skidPc, skidPcNext;

   logic              bufFree;
   logic              xfer;
   logic [ADDR_W-1:0] redirTarget;
   logic [ADDR_W-1:0] pcInc;

   assign bufFree     = !outValid || dec_ready;
   assign xfer        = outValid && dec_ready;
   assign redirTarget = redirect_pc & ~ADDR_W'(3);
   assign pcInc       = pc + ADDR_W'(4);

   always_comb begin
      stateNext     = state;
      pcNext        = pc;
      drainAddrNext = drainAddr;
      outValidNext  = outValid;
      outInstrNext  = outInstr;
      outPcNext     = outPc;
      nextOpNext    = nextOp;
      skidValidNext = skidValid;
      skidInstrNext = skidInstr;
      skidPcNext    = skidPc;

      // A consumed word empties the output register unless something reloads it below.
      if (xfer) begin
         outValidNext = 1'b0;
         nextOpNext   = NOP_OP;
      end

      case (state)
         IDLE: begin
            stateNext = REQ;
            if (redirect_valid) pcNext = redirTarget;
         end
         REQ: begin
            if (redirect_valid) begin
               pcNext = redirTarget;
               // The bus request cannot be withdrawn, so remember its address and absorb the reply.
               if (!imem_ack) begin
                  stateNext     = DRAIN;
                  drainAddrNext = pc;
               end
            end else if (imem_ack) begin
               pcNext = pcInc;
               if (bufFree) begin
                  outValidNext = 1'b1;
                  outInstrNext = imem_rdata;
                  outPcNext    = pc;
                  nextOpNext   = imem_rdata[31:27];
               end else begin
                  skidValidNext = 1'b1;
                  skidInstrNext = imem_rdata;
                  skidPcNext    = pc;
                  stateNext     = HOLD;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pcNext    = redirTarget;
               stateNext = REQ;
            end else if (dec_ready) begin
               outValidNext  = skidValid;
               outInstrNext  = skidInstr;
               outPcNext     = skidPc;
               nextOpNext    = skidValid ? skidInstr[31:27] : NOP_OP;
               skidValidNext = 1'b0;
               stateNext     = REQ;
            end
         end
         DRAIN: begin
            if (redirect_valid) pcNext = redirTarget;
            if (imem_ack) stateNext = REQ;
         end
         default: stateNext = IDLE;
      endcase

      if (redirect_valid && (state != IDLE)) begin
         outValidNext  = 1'b0;
         skidValidNext = 1'b0;
         nextOpNext    = NOP_OP;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pc        <= RESET_PC;
         drainAddr <= RESET_PC;
         outValid  <= 1'b0;
         outInstr  <= '0;
         outPc     <= '0;
         nextOp    <= NOP_OP;
         skidValid <= 1'b0;
         skidInstr <= '0;
         skidPc    <= '0;
      end else begin
         state     <= stateNext;
         pc        <= pcNext;
         drainAddr <= drainAddrNext;
         outValid  <= outValidNext;
         outInstr  <= outInstrNext;
         outPc     <= outPcNext;
         nextOp    <= nextOpNext;
         skidValid <= skidValidNext;
         skidInstr <= skidInstrNext;
         skidPc    <= skidPcNext;
      end
   end

   assign imem_req    = (state == REQ) || (state == DRAIN);
   assign imem_addr   = (state == DRAIN) ? drainAddr : pc;
   assign dec_valid   = outValid;
   assign dec_instr   = outInstr;
   assign dec_pc      = outPc;
   assign next_opCode = nextOp;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: latency-programmable memory model, decode-side monitor,
// and a second instance with a near-top RESET_PC for wrap and asynchronous-reset checks.
module tb_fetch_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, imem_req, imem_ack, dec_valid, dec_ready, redirect_valid;
   logic [31:0] imem_addr, imem_rdata, dec_instr, dec_pc, redirect_pc;
   logic [4:0]  next_opCode;

   logic        wRstN, wReq, wAck, wValid, wReady, wRedir;
   logic [31:0] wAddr, wRdata, wInstr, wPc, wRedirPc;
   logic [4:0]  wOp;

   int nCompared = 0;
   int nMismatch = 0;
   int cyc = 0;
   int lat;
   int waitCnt;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [4:0]  op;
      int          cyc;
   } xfer_t;

   xfer_t obsQ[$];
   xfer_t expQ[$];

   fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_OP(5'd0)) dut (
      .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .dec_valid(dec_valid),
      .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
      .next_opCode(next_opCode), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   fetch_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFF8), .NOP_OP(5'h1F)) dutWrap (
      .clk(clk), .rst_n(wRstN), .imem_req(wReq), .imem_addr(wAddr),
      .imem_ack(wAck), .imem_rdata(wRdata), .dec_valid(wValid),
      .dec_ready(wReady), .dec_instr(wInstr), .dec_pc(wPc),
      .next_opCode(wOp), .redirect_valid(wRedir), .redirect_pc(wRedirPc)
   );

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return (a * 32'h0019_660D) ^ 32'hB5A3_C001;
   endfunction

   // Memory model: acks on the lat-th cycle of a request (lat<=1 means same cycle); reset with the core.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) waitCnt <= 0;
      else if (imem_req && !imem_ack) waitCnt <= waitCnt + 1;
      else waitCnt <= 0;
   end

   always_comb begin
      imem_ack   = imem_req && (waitCnt >= lat - 1);
      imem_rdata = memWord(imem_addr);
      wAck       = wReq;
      wRdata     = memWord(wAddr);
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      xfer_t o;
      if (rst_n && dec_valid && dec_ready) begin
         o.pc = dec_pc; o.instr = dec_instr; o.op = next_opCode; o.cyc = cyc;
         obsQ.push_back(o);
      end
   end

   task automatic pushExp(input logic [31:0] pc);
      xfer_t e;
      e.pc = pc; e.instr = memWord(pc); e.op = e.instr[31:27]; e.cyc = 0;
      expQ.push_back(e);
   endtask

   task automatic applyReset(input int latVal, input logic readyVal);
      rst_n = 1'b0; lat = latVal; dec_ready = readyVal;
      redirect_valid = 1'b0; redirect_pc = '0;
      repeat (2) @(posedge clk);
      #1;
      obsQ.delete(); expQ.delete();
      rst_n = 1'b1;
   endtask

   task automatic waitObs(input int n, input int budget);
      for (int i = 0; i < budget && obsQ.size() < n; i++) @(posedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; lat = 0; dec_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nCompared++; if (imem_req !== 1'b0) begin nMismatch++; $display("FAIL rst_req: got %b, expected 0", imem_req); end
      nCompared++; if (imem_addr !== 32'h0) begin nMismatch++; $display("FAIL rst_addr: got %h, expected 0", imem_addr); end
      nCompared++; if (dec_valid !== 1'b0) begin nMismatch++; $display("FAIL rst_valid: got %b, expected 0", dec_valid); end
      nCompared++; if (dec_instr !== 32'h0) begin nMismatch++; $display("FAIL rst_instr: got %h, expected 0", dec_instr); end
      nCompared++; if (dec_pc !== 32'h0) begin nMismatch++; $display("FAIL rst_pc: got %h, expected 0", dec_pc); end
      nCompared++; if (next_opCode !== 5'd0) begin nMismatch++; $display("FAIL rst_op: got %h, expected 0", next_opCode); end
      @(posedge clk); #1 rst_n = 1'b1;
      @(negedge clk);
      nCompared++; if (imem_req !== 1'b0) begin nMismatch++; $display("FAIL rst_bubble: got req=%b, expected 0", imem_req); end
      @(negedge clk);
      nCompared++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
         nMismatch++; $display("FAIL rst_first_req: got req=%b addr=%h, expected req=1 addr=0", imem_req, imem_addr);
      end
   endtask

   task automatic test_zero_wait;
      xfer_t e, o;
      int firstCyc;
      applyReset(0, 1'b1);
      for (int i = 0; i < 4; i++) pushExp(32'(i * 4));
      waitObs(4, 20);
      nCompared++;
      if (obsQ.size() < 4) begin
         nMismatch++; $display("FAIL zw_count: got %0d transfers, expected 4", obsQ.size());
      end else begin
         firstCyc = obsQ[0].cyc;
         for (int i = 0; i < 4; i++) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
            if (o.pc !== e.pc || o.instr !== e.instr || o.op !== e.op || o.cyc !== firstCyc + i) begin
               nMismatch++;
               $display("FAIL zw_seq[%0d]: got pc=%h instr=%h op=%h cyc=%0d, expected pc=%h instr=%h op=%h cyc=%0d",
                        i, o.pc, o.instr, o.op, o.cyc, e.pc, e.instr, e.op, firstCyc + i);
            end
         end
      end
   endtask

   task automatic test_latency;
      xfer_t e, o;
      int firstCyc;
      logic prevWait, prevValid;
      logic [31:0] prevAddr;
      applyReset(3, 1'b1);
      for (int i = 0; i < 3; i++) pushExp(32'(i * 4));
      prevWait = 1'b0; prevValid = 1'b0; prevAddr = '0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (prevWait && imem_req) begin
            nCompared++;
            if (imem_addr !== prevAddr) begin nMismatch++; $display("FAIL lat_addr_stable: got %h, expected %h", imem_addr, prevAddr); end
         end
         nCompared++;
         if (prevValid && dec_valid) begin nMismatch++; $display("FAIL lat_pulse: got dec_valid=1 two cycles running, expected single-cycle pulse"); end
         prevWait = imem_req && !imem_ack; prevAddr = imem_addr; prevValid = dec_valid;
      end
      waitObs(3, 10);
      nCompared++;
      if (obsQ.size() < 3) begin
         nMismatch++; $display("FAIL lat_count: got %0d transfers, expected 3", obsQ.size());
      end else begin
         firstCyc = obsQ[0].cyc;
         for (int i = 0; i < 3; i++) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
            if (o.pc !== e.pc || o.instr !== e.instr || o.op !== e.op || o.cyc !== firstCyc + 3 * i) begin
               nMismatch++;
               $display("FAIL lat_seq[%0d]: got pc=%h instr=%h cyc=%0d, expected pc=%h instr=%h cyc=%0d",
                        i, o.pc, o.instr, o.cyc, e.pc, e.instr, firstCyc + 3 * i);
            end
         end
      end
   endtask

   task automatic test_backpressure;
      xfer_t e, o;
      int firstCyc;
      logic found;
      logic [31:0] w0;
      logic [4:0] op0;
      w0 = memWord(32'h0); op0 = w0[31:27];
      applyReset(0, 1'b0);
      for (int i = 0; i < 3; i++) pushExp(32'(i * 4));
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin @(negedge clk); found = dec_valid; end
      nCompared++; if (!found) begin nMismatch++; $display("FAIL bp_first_valid: got no dec_valid in 10 cycles, expected one"); end
      for (int k = 0; k < 5; k++) begin
         if (k > 0) @(negedge clk);
         nCompared++;
         if (dec_valid !== 1'b1 || dec_pc !== 32'h0 || dec_instr !== w0 || next_opCode !== op0) begin
            nMismatch++;
            $display("FAIL bp_hold[%0d]: got v=%b pc=%h instr=%h op=%h, expected v=1 pc=0 instr=%h op=%h",
                     k, dec_valid, dec_pc, dec_instr, next_opCode, w0, op0);
         end
         if (k > 0) begin
            nCompared++; if (imem_req !== 1'b0) begin nMismatch++; $display("FAIL bp_req[%0d]: got %b, expected 0", k, imem_req); end
         end
      end
      @(posedge clk); #1 dec_ready = 1'b1;
      waitObs(3, 10);
      nCompared++;
      if (obsQ.size() < 3) begin
         nMismatch++; $display("FAIL bp_count: got %0d transfers, expected 3", obsQ.size());
      end else begin
         firstCyc = obsQ[0].cyc;
         for (int i = 0; i < 3; i++) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
            if (o.pc !== e.pc || o.instr !== e.instr || o.op !== e.op || o.cyc !== firstCyc + i) begin
               nMismatch++;
               $display("FAIL bp_seq[%0d]: got pc=%h instr=%h cyc=%0d, expected pc=%h instr=%h cyc=%0d",
                        i, o.pc, o.instr, o.cyc, e.pc, e.instr, firstCyc + i);
            end
         end
      end
   endtask

   task automatic test_redirect_pending;
      xfer_t e, o;
      logic found;
      applyReset(3, 1'b1);
      pushExp(32'h0); pushExp(32'h4); pushExp(32'h100); pushExp(32'h104);
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         found = imem_req && !imem_ack && (imem_addr === 32'h8);
      end
      nCompared++; if (!found) begin nMismatch++; $display("FAIL rp_wait: got no pending request for 0x8, expected one"); end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      @(posedge clk); #1 redirect_valid = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(negedge clk);
         if (imem_req && imem_addr !== 32'h8) found = 1'b1;
         else begin
            nCompared++; if (dec_valid !== 1'b0) begin nMismatch++; $display("FAIL rp_gap_valid: got %b, expected 0", dec_valid); end
         end
      end
      nCompared++;
      if (!found || imem_addr !== 32'h100) begin
         nMismatch++; $display("FAIL rp_new_addr: got %h, expected 00000100", imem_addr);
      end
      waitObs(4, 20);
      nCompared++;
      if (obsQ.size() < 4) begin
         nMismatch++; $display("FAIL rp_count: got %0d transfers, expected 4", obsQ.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
            if (o.pc !== e.pc || o.instr !== e.instr || o.op !== e.op) begin
               nMismatch++;
               $display("FAIL rp_seq[%0d]: got pc=%h instr=%h, expected pc=%h instr=%h", i, o.pc, o.instr, e.pc, e.instr);
            end
         end
      end
   endtask

   task automatic test_redirect_ack;
      xfer_t e, o;
      logic found;
      applyReset(3, 1'b1);
      pushExp(32'h0); pushExp(32'h200); pushExp(32'h204);
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         @(negedge clk);
         found = imem_req && imem_ack && (imem_addr === 32'h4);
      end
      nCompared++; if (!found) begin nMismatch++; $display("FAIL ra_wait: got no ack for 0x4, expected one"); end
      redirect_valid = 1'b1; redirect_pc = 32'h203;
      @(posedge clk); #1 redirect_valid = 1'b0;
      @(negedge clk);
      nCompared++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h200 || dec_valid !== 1'b0) begin
         nMismatch++;
         $display("FAIL ra_next: got req=%b addr=%h v=%b, expected req=1 addr=00000200 v=0", imem_req, imem_addr, dec_valid);
      end
      waitObs(3, 20);
      nCompared++;
      if (obsQ.size() < 3) begin
         nMismatch++; $display("FAIL ra_count: got %0d transfers, expected 3", obsQ.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); nCompared++;
            if (o.pc !== e.pc || o.instr !== e.instr || o.op !== e.op) begin
               nMismatch++;
               $display("FAIL ra_seq[%0d]: got pc=%h instr=%h, expected pc=%h instr=%h", i, o.pc, o.instr, e.pc, e.instr);
            end
         end
      end
   endtask

   task automatic test_wrap;
      logic [31:0] got[$];
      logic [31:0] wExp[3];
      wExp[0] = 32'hFFFF_FFF8; wExp[1] = 32'hFFFF_FFFC; wExp[2] = 32'h0;
      wRstN = 1'b0; wReady = 1'b1; wRedir = 1'b0; wRedirPc = '0;
      repeat (2) @(posedge clk);
      #1 wRstN = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (wValid) got.push_back(wPc);
      end
      nCompared++;
      if (got.size() < 3) begin
         nMismatch++; $display("FAIL wrap_count: got %0d transfers, expected at least 3", got.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            nCompared++;
            if (got[i] !== wExp[i]) begin nMismatch++; $display("FAIL wrap_pc[%0d]: got %h, expected %h", i, got[i], wExp[i]); end
         end
      end
      @(posedge clk); #3;
      nCompared++; if (wValid !== 1'b1) begin nMismatch++; $display("FAIL wrap_streaming: got dec_valid=%b, expected 1", wValid); end
      wRstN = 1'b0;
      #1;
      nCompared++;
      if (wReq !== 1'b0 || wAddr !== 32'hFFFF_FFF8 || wValid !== 1'b0 || wInstr !== 32'h0 || wPc !== 32'h0 || wOp !== 5'h1F) begin
         nMismatch++;
         $display("FAIL async_rst: got req=%b addr=%h v=%b instr=%h pc=%h op=%h, expected req=0 addr=fffffff8 v=0 instr=0 pc=0 op=1f",
                  wReq, wAddr, wValid, wInstr, wPc, wOp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; wRstN = 1'b0; lat = 0; dec_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      wReady = 1'b1; wRedir = 1'b0; wRedirPc = '0;
      test_reset;
      test_zero_wait;
      test_latency;
      test_backpressure;
      test_redirect_pending;
      test_redirect_ack;
      test_wrap;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
